// File: rtl/fan_duty_scheduler_pkg.sv
// Shared definitions for the fan duty scheduler: FSM state codes, one-hot
// requester selects and the saturating ramp-step helper.
package fan_duty_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [2:0] MODE_DEFAULT = 3'b001;
  localparam logic [2:0] MODE_AUTO    = 3'b010;
  localparam logic [2:0] MODE_NATURAL = 3'b100;

  // Move cur toward tgt by at most up (rising) or dn (falling).
  // Lands exactly on tgt when the remaining gap fits in one step, so the
  // result never overshoots and never wraps past 0 or 255.
  function automatic logic [7:0] step_toward(
    input logic [7:0] cur,
    input logic [7:0] tgt,
    input logic [8:0] up,
    input logic [8:0] dn
  );
    logic [8:0] gap;
    logic [7:0] res;
    res = tgt;
    if (tgt > cur) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      if (gap > up) res = cur + up[7:0];
    end else begin
      gap = {1'b0, cur} - {1'b0, tgt};
      if (gap > dn) res = cur - dn[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fan_duty_scheduler_pwm.sv
// 8-bit PWM generator: prescaled counter, compare level latched at each
// counter wrap, plus an immediate-clear input that forces the output low.
module pwm_gen8 #(
  parameter int PWM_DIV = 392
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] duty,
  input  logic       clear,
  output logic       pwm
);

  localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PWM_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [7:0]    cnt_reg;
  logic [7:0]    level_reg;
  logic          advance;

  assign advance = (div_reg == DIV_MAX);

  // Prescaler: one advance pulse every PWM_DIV clocks.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)      div_reg <= '0;
    else if (advance) div_reg <= '0;
    else              div_reg <= div_reg + 1'b1;
  end

  // Period counter, wraps 255 -> 0 naturally.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)      cnt_reg <= 8'd0;
    else if (advance) cnt_reg <= cnt_reg + 8'd1;
  end

  // Compare level: sampled only at wrap so periods are never torn;
  // clear wins so a forced-off motor stops on the very next cycle.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)                              level_reg <= 8'd0;
    else if (clear)                           level_reg <= 8'd0;
    else if (advance && cnt_reg == 8'hFF)     level_reg <= duty;
  end

  assign pwm = (cnt_reg < level_reg);

endmodule

// File: rtl/fan_duty_scheduler.sv
// Fan duty scheduler: selects a requested duty by one-hot mode, ramps the
// applied duty toward it in timed steps, handles pause/off requests, and
// drives the motor PWM through pwm_gen8.
module fan_duty_scheduler
  import fan_duty_scheduler_pkg::*;
#(
  parameter int RAMP_TICK = 100000,
  parameter int STEP_UP   = 5,
  parameter int STEP_DN   = 10,
  parameter int PWM_DIV   = 392
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [2:0] mode,
  input  logic [7:0] duty_d,
  input  logic [7:0] duty_a,
  input  logic [7:0] duty_n,
  input  logic       pause,
  input  logic       off_req,
  output logic [7:0] duty_out,
  output logic       pwm,
  output logic [2:0] state,
  output logic       ramping,
  output logic       mode_err
);

  localparam int TW = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(RAMP_TICK - 1);
  localparam logic [8:0] UP9 = 9'(STEP_UP);
  localparam logic [8:0] DN9 = 9'(STEP_DN);

  state_t        state_reg, state_next;
  logic [7:0]    duty_reg, duty_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic          armed_reg, armed_next;
  logic          mode_err_reg;
  logic [7:0]    target;
  logic          mode_bad;
  logic          tick_hit;
  logic          level_clear;

  assign mode_bad = !((mode == MODE_DEFAULT) || (mode == MODE_AUTO) ||
                      (mode == MODE_NATURAL));
  assign tick_hit = (tick_reg == TICK_MAX);

  // Requester select; anything that is not exactly one-hot asks for zero.
  always_comb begin
    target = 8'd0;
    case (mode)
      MODE_DEFAULT: target = duty_d;
      MODE_AUTO:    target = duty_a;
      MODE_NATURAL: target = duty_n;
      default:      target = 8'd0;
    endcase
  end

  // State, duty, tick counter, arm flag and mode error registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_reg    <= ST_IDLE;
      duty_reg     <= 8'd0;
      tick_reg     <= '0;
      armed_reg    <= 1'b1;
      mode_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      duty_reg     <= duty_next;
      tick_reg     <= tick_next;
      armed_reg    <= armed_next;
      mode_err_reg <= mode_bad;
    end
  end

  // Next-state, ramp stepping and arm tracking. Every entry into RAMP or
  // STOP restarts the tick counter so the first step is a full interval away.
  always_comb begin
    state_next  = state_reg;
    duty_next   = duty_reg;
    tick_next   = tick_reg;
    armed_next  = armed_reg;
    level_clear = 1'b0;
    if (target == 8'd0) armed_next = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        duty_next = 8'd0;
        if (armed_reg && target != 8'd0 && !pause) begin
          state_next = ST_RAMP;
          tick_next  = '0;
        end
      end
      ST_RAMP, ST_HOLD: begin
        if (pause && off_req) begin
          state_next  = ST_IDLE;
          duty_next   = 8'd0;
          level_clear = 1'b1;
        end else if (pause) begin
          state_next  = ST_PAUSE;
          duty_next   = 8'd0;
          level_clear = 1'b1;
        end else if (off_req) begin
          state_next = ST_STOP;
          tick_next  = '0;
        end else if (state_reg == ST_HOLD) begin
          if (target != duty_reg) begin
            state_next = ST_RAMP;
            tick_next  = '0;
          end
        end else if (duty_reg == target && target != 8'd0) begin
          state_next = ST_HOLD;
        end else if (duty_reg == 8'd0 && target == 8'd0) begin
          state_next = ST_IDLE;
        end else if (tick_hit) begin
          duty_next = step_toward(duty_reg, target, UP9, DN9);
          tick_next = '0;
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end
      ST_PAUSE: begin
        duty_next = 8'd0;
        if (pause && off_req) begin
          state_next  = ST_IDLE;
          level_clear = 1'b1;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end else if (off_req) begin
          state_next = ST_STOP;
          tick_next  = '0;
        end else begin
          state_next = (target != 8'd0) ? ST_RAMP : ST_IDLE;
          tick_next  = '0;
        end
      end
      ST_STOP: begin
        if (pause) begin
          state_next  = ST_IDLE;
          duty_next   = 8'd0;
          level_clear = 1'b1;
          armed_next  = 1'b0;
        end else if (duty_reg == 8'd0) begin
          state_next = ST_IDLE;
          armed_next = 1'b0;
        end else if (tick_hit) begin
          duty_next = step_toward(duty_reg, 8'd0, UP9, DN9);
          tick_next = '0;
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        duty_next   = 8'd0;
        tick_next   = '0;
        level_clear = 1'b1;
      end
    endcase
  end

  pwm_gen8 #(.PWM_DIV(PWM_DIV)) u_pwm (
    .clk     (clk),
    .reset_p (reset_p),
    .duty    (duty_reg),
    .clear   (level_clear),
    .pwm     (pwm)
  );

  assign duty_out = duty_reg;
  assign state    = state_reg;
  assign ramping  = (state_reg == ST_RAMP) || (state_reg == ST_STOP);
  assign mode_err = mode_err_reg;

endmodule

// File: tb/tb_fan_duty_scheduler.sv
// Directed-plus-random bench for fan_duty_scheduler (RAMP_TICK=4,
// STEP_UP=5, STEP_DN=10, PWM_DIV=1). Expected ramp values come from closed
// forms (start +/- step*k, clipped at the target); PWM expectations come
// from counting high cycles over whole 256-cycle periods.
module tb_fan_duty_scheduler;

  localparam int RT = 4;
  localparam int SU = 5;
  localparam int SD = 10;
  localparam int S_IDLE = 0, S_RAMP = 1, S_HOLD = 2, S_PAUSE = 3, S_STOP = 4;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic [2:0] mode = 3'b001;
  logic [7:0] duty_d = 8'd0, duty_a = 8'd0, duty_n = 8'd0;
  logic       pause = 1'b0, off_req = 1'b0;
  logic [7:0] duty_out;
  logic       pwm;
  logic [2:0] state;
  logic       ramping, mode_err;

  int errors = 0;
  int checks = 0;

  fan_duty_scheduler #(
    .RAMP_TICK(RT), .STEP_UP(SU), .STEP_DN(SD), .PWM_DIV(1)
  ) dut (
    .clk(clk), .reset_p(reset_p), .mode(mode),
    .duty_d(duty_d), .duty_a(duty_a), .duty_n(duty_n),
    .pause(pause), .off_req(off_req),
    .duty_out(duty_out), .pwm(pwm), .state(state),
    .ramping(ramping), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic note(input string what, input int a, input int b);
    $display("[%0t] %s (%0d -> %0d)", $time, what, a, b);
  endtask

  // Called right after RAMP (or STOP) is entered; checks every step
  // against start +/- step*k clipped at tgt, then the settling state.
  task automatic ramp_to(input int from, input int tgt, input string tag);
    int k;
    int exp;
    k = 0;
    exp = from;
    note(tag, from, tgt);
    while (exp != tgt) begin
      k++;
      step(RT);
      if (tgt > from) exp = (from + SU * k < tgt) ? from + SU * k : tgt;
      else            exp = (from - SD * k > tgt) ? from - SD * k : tgt;
      chk(tag, duty_out, exp);
    end
    step(1);
    chk({tag, "_end_state"}, state, (tgt != 0) ? S_HOLD : S_IDLE);
    chk({tag, "_end_ramping"}, ramping, 0);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (pwm === 1'b1) hi++;
    end
  endtask

  initial begin
    int cur;
    int t;
    int hi;
    int found;
    logic [2:0] bad_modes [5];
    logic [2:0] modes3 [3];
    bad_modes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    modes3    = '{3'b001, 3'b010, 3'b100};

    // Reset state
    step(3);
    chk("rst_state", state, S_IDLE);
    chk("rst_duty", duty_out, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_ramping", ramping, 0);
    chk("rst_mode_err", mode_err, 0);
    reset_p = 1'b0;
    step(2);
    chk("idle_state", state, S_IDLE);

    // Default requester 0 -> 23
    duty_d = 8'd23;
    step(1);
    chk("start_state", state, S_RAMP);
    chk("start_ramping", ramping, 1);
    ramp_to(0, 23, "up23");

    // Power-off from HOLD, then re-arm only after target goes to 0
    off_req = 1'b1;
    step(1);
    off_req = 1'b0;
    chk("stop_state", state, S_STOP);
    chk("stop_ramping", ramping, 1);
    ramp_to(23, 0, "stop23");
    step(10);
    chk("disarmed_idle", state, S_IDLE);
    duty_d = 8'd0;
    step(1);
    chk("rearm_idle", state, S_IDLE);
    duty_d = 8'd23;
    step(1);
    chk("rearm_ramp", state, S_RAMP);
    ramp_to(0, 23, "rearm23");
    cur = 23;

    // Random targets across all three requesters
    for (int r = 0; r < 4; r++) begin
      t = $urandom_range(30, 250);
      if (t == cur) t = t + 1;
      duty_d = 8'($urandom_range(1, 255));
      duty_a = 8'($urandom_range(1, 255));
      duty_n = 8'($urandom_range(1, 255));
      mode = modes3[r % 3];
      case (r % 3)
        0: duty_d = 8'(t);
        1: duty_a = 8'(t);
        default: duty_n = 8'(t);
      endcase
      step(1);
      chk("rand_ramp_state", state, S_RAMP);
      chk("rand_mode_err", mode_err, 0);
      ramp_to(cur, t, "rand");
      cur = t;
    end

    // Pause from HOLD at 200
    mode = 3'b001;
    duty_d = 8'd200;
    if (cur != 200) begin
      step(1);
      chk("to200_state", state, S_RAMP);
      ramp_to(cur, 200, "up200");
    end
    step(300);
    pause = 1'b1;
    step(1);
    chk("pause_state", state, S_PAUSE);
    chk("pause_duty", duty_out, 0);
    chk("pause_pwm", pwm, 0);
    count_high(20, hi);
    chk("pause_pwm_quiet", hi, 0);
    pause = 1'b0;
    step(1);
    chk("resume_state", state, S_RAMP);
    chk("resume_duty", duty_out, 0);
    ramp_to(0, 200, "resume200");

    // Illegal mode -> target 0 and mode_err
    mode = bad_modes[$urandom_range(0, 4)];
    step(1);
    chk("bad_mode_err", mode_err, 1);
    chk("bad_mode_state", state, S_RAMP);
    ramp_to(200, 0, "badmode_down");
    chk("bad_mode_err_hold", mode_err, 1);
    mode = 3'b010;
    duty_a = 8'd80;
    step(1);
    chk("auto_mode_err", mode_err, 0);
    chk("auto_state", state, S_RAMP);
    ramp_to(0, 80, "auto80");

    // Full duty: 255 of 256 cycles high
    duty_a = 8'd255;
    step(1);
    chk("to255_state", state, S_RAMP);
    ramp_to(80, 255, "up255");
    step(256);
    count_high(256, hi);
    chk("pwm_255_high", hi, 255);

    // Duty change mid-period waits for the wrap
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      step(1);
      if (pwm === 1'b0) found = 1;
    end
    chk("pwm_wrap_seen", found, 1);
    duty_a = 8'd100;
    count_high(256, hi);
    chk("pwm_period_kept", hi, 255);
    count_high(256, hi);
    chk("pwm_new_period", hi, 100);
    chk("hold100_state", state, S_HOLD);
    chk("hold100_duty", duty_out, 100);

    // Asynchronous reset mid-ramp at duty 100
    duty_a = 8'd150;
    step(1);
    chk("pre_rst_state", state, S_RAMP);
    step(2);
    chk("pre_rst_duty", duty_out, 100);
    #2 reset_p = 1'b1;
    #1;
    chk("async_rst_state", state, S_IDLE);
    chk("async_rst_duty", duty_out, 0);
    chk("async_rst_pwm", pwm, 0);
    chk("async_rst_ramping", ramping, 0);
    chk("async_rst_mode_err", mode_err, 0);
    #1 reset_p = 1'b0;
    step(1);
    chk("post_rst_state", state, S_RAMP);
    ramp_to(0, 150, "post_rst150");

    // pause + off_req together from HOLD
    pause = 1'b1;
    off_req = 1'b1;
    step(1);
    pause = 1'b0;
    off_req = 1'b0;
    chk("pause_off_state", state, S_IDLE);
    chk("pause_off_duty", duty_out, 0);
    chk("pause_off_pwm", pwm, 0);
    step(1);
    chk("pause_off_rerun", state, S_RAMP);
    step(2 * RT);
    chk("rerun_duty", duty_out, 2 * SU);

    // pause inside STOP
    off_req = 1'b1;
    step(1);
    off_req = 1'b0;
    chk("stop2_state", state, S_STOP);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk("stop_pause_state", state, S_IDLE);
    chk("stop_pause_duty", duty_out, 0);
    chk("stop_pause_pwm", pwm, 0);
    off_req = 1'b1;
    step(1);
    off_req = 1'b0;
    chk("idle_off_ignored", state, S_IDLE);
    step(5);
    chk("stop_pause_disarmed", state, S_IDLE);
    duty_a = 8'd0;
    step(1);
    duty_a = 8'd60;
    step(1);
    chk("final_rearm", state, S_RAMP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fan_duty_scheduler.md
FAN_DUTY_SCHEDULER -- requirements
Module: fan_duty_scheduler

Interface
REQ-001 SHALL have parameter RAMP_TICK, default 100000, meaning clk cycles between ramp steps.
REQ-002 SHALL have parameter STEP_UP, default 5, meaning duty increment per ramp-up step.
REQ-003 SHALL have parameter STEP_DN, default 10, meaning duty decrement per ramp-down step.
REQ-004 SHALL have parameter PWM_DIV, default 392, meaning clk cycles per PWM counter increment.
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset_p  in  1  reset, asynchronous, active-high.
- mode  in  3  one-hot requester select: 001 default, 010 auto, 100 natural.
- duty_d / duty_a / duty_n  in  8 each  requested duty per mode.
- pause  in  1  level; object-detect hold.
- off_req  in  1  single-cycle power-off/timeout pulse.
- duty_out  out  8  applied (ramped) duty.
- pwm  out  1  motor PWM.
- state  out  3  FSM state code.
- ramping  out  1  high in RAMP or STOP.
- mode_err  out  1  registered flag: mode not one-hot.

Function
REQ-006 SHALL form target from the selected requester by mode; non-one-hot mode SHALL give target=0 and set mode_err on the next cycle, for as long as the condition persists.
REQ-007 SHALL implement states IDLE=0, RAMP=1, HOLD=2, PAUSE=3, STOP=4; other codes SHALL return to IDLE.
REQ-008 IDLE: duty_out=0; SHALL go to RAMP when armed, target!=0 and pause=0.
REQ-009 "armed" SHALL clear on entry to IDLE from STOP and set after target=0 for at least one cycle; it is set out of reset.
REQ-010 RAMP: an internal tick counter SHALL fire every RAMP_TICK cycles; on each tick duty_out SHALL move toward target by STEP_UP (up) or STEP_DN (down).
REQ-011 Steps SHALL saturate: if |target-duty_out| <= step, duty_out=target; no overshoot, no 8-bit wrap.
REQ-012 RAMP SHALL go to HOLD when duty_out==target!=0, and to IDLE when duty_out reaches 0 with target=0.
REQ-013 HOLD: on target!=duty_out, SHALL go to RAMP with tick counter cleared.
REQ-014 Entering RAMP from IDLE or PAUSE SHALL clear the tick counter; first step occurs RAMP_TICK cycles later.
REQ-015 pause=1 in RAMP or HOLD SHALL go to PAUSE with duty_out=0 on the next cycle.
REQ-016 PAUSE: on pause=0, SHALL go to RAMP from 0 toward the current target, or to IDLE if target=0.
REQ-017 off_req in RAMP, HOLD or PAUSE SHALL go to STOP; off_req in IDLE or STOP SHALL be ignored.
REQ-018 STOP: SHALL ignore target and ramp duty_out down by STEP_DN per tick, going to IDLE when 0.
REQ-019 pause=1 in STOP, or pause and off_req in the same cycle, SHALL force duty_out=0 and go to IDLE on the next cycle.
REQ-020 The PWM counter SHALL be 8 bits, advancing once per PWM_DIV cycles and wrapping 255->0.
REQ-021 The PWM compare value SHALL latch duty_out when the counter wraps to 0; pwm = (cnt < latched duty). Duty 0 gives constant low; duty 255 gives 255/256 high.
REQ-022 Exception to REQ-021: duty_out becoming 0 via PAUSE or REQ-019 SHALL clear the latched duty immediately, so pwm is low on the next cycle.

Reset
REQ-023 On reset_p SHALL set: state=IDLE, duty_out=0, pwm=0, ramping=0, mode_err=0, all counters 0, latched duty 0, armed=1.
REQ-024 Reset asserted mid-ramp or mid-PWM period SHALL take effect immediately, without waiting for clk.

Structure
REQ-025 State codes and the mode one-hot constants (DEFAULT/AUTO/NATURAL) SHALL live in a shared package used by the top level and this block.
REQ-026 The PWM generator SHALL be a sub-module, pwm_gen8 (counter, prescaler, wrap-latch, immediate-clear input); ramp/FSM logic stays in fan_duty_scheduler.

Verification (RAMP_TICK=4, STEP_UP=5, STEP_DN=10, PWM_DIV=1)
REQ-027 mode=001, duty_d=0->23 -> RAMP; duty_out 5,10,15,20,23 at 4-cycle intervals; then HOLD, ramping=0.
REQ-028 In HOLD at 23, off_req pulse -> STOP; duty_out 13,3,0; IDLE; duty_d held 23 -> stays IDLE until duty_d=0 then 23 again.
REQ-029 In HOLD at 200, pause=1 -> duty_out=0 and pwm=0 next cycle; pause=0 -> RAMP from 0 by 5 toward 200.
REQ-030 mode=011 -> target 0, mode_err=1; ramps down to IDLE; mode=010 with duty_a=80 -> mode_err=0 and ramp to 80.
REQ-031 duty_out=255 held -> pwm high 255 of 256 cycles; duty changes mid-period take effect only at counter wrap.
REQ-032 Reset pulse mid-ramp at duty 100 -> all outputs 0 and state IDLE immediately, before the next clk edge.
